// File: rtl/two_bit_1to4_demux_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-4 demultiplexer.
package two_bit_1to4_demux_reg_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t CH_U = 2'd0;
    localparam sel_t CH_V = 2'd1;
    localparam sel_t CH_W = 2'd2;
    localparam sel_t CH_X = 2'd3;

    typedef enum logic {
        SEL_EXPLICIT = 1'b0,
        SEL_AUTO     = 1'b1
    } sel_mode_e;

    function automatic logic [NCH-1:0] chan_onehot(input sel_t ch);
        logic [NCH-1:0] oh;
        case (ch)
            CH_U:    oh = 4'b0001;
            CH_V:    oh = 4'b0010;
            CH_W:    oh = 4'b0100;
            CH_X:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // The select width makes the round-robin wrap from 3 to 0 implicit.
    function automatic sel_t ptr_next(input sel_t p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/two_bit_1to4_demux_reg_if.sv
// Source and consumer handshake bundle of the 1-to-4 demultiplexer.
interface two_bit_1to4_demux_reg_if
    import two_bit_1to4_demux_reg_pkg::*;
#(
    parameter int WIDTH = 2
);

    logic [SEL_W-1:0] s;
    logic             auto;
    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] x;
    logic [NCH-1:0]   out_valid;
    logic [NCH-1:0]   out_ack;
    logic [SEL_W-1:0] ptr;

    modport slave (
        input  s, auto, d, in_valid, out_ack,
        output in_ready, u, v, w, x, out_valid, ptr
    );

    modport master (
        output s, auto, d, in_valid, out_ack,
        input  in_ready, u, v, w, x, out_valid, ptr
    );

endinterface

// File: rtl/two_bit_1to4_demux_reg_slot.sv
// Single-entry holding slot: a data register plus its valid flag.
module demux_slot #(
    parameter int WIDTH = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             wr,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_valid_nxt;

    // A write wins over a same-cycle ack; data is held when the word is taken.
    always_comb begin
        w_q_nxt     = r_q;
        w_valid_nxt = r_valid;
        if (wr) begin
            w_q_nxt     = d;
            w_valid_nxt = 1'b1;
        end else if (ack && r_valid) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid;
        end
    end

    // Slot state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_q     <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign q     = r_q;
    assign valid = r_valid;

endmodule

// File: rtl/two_bit_1to4_demux_reg.sv
// Registered 1-to-4 demultiplexer steering each accepted word into slot u/v/w/x.
module two_bit_1to4_demux_reg
    import two_bit_1to4_demux_reg_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    two_bit_1to4_demux_reg_if.slave  bus
);

    sel_t             r_ptr;
    sel_t             w_ptr_nxt;
    sel_t             w_dest;
    logic             w_in_ready;
    logic             w_accept;
    logic [NCH-1:0]   w_wr;
    logic [NCH-1:0]   w_valid;
    logic [WIDTH-1:0] w_q [NCH];

    // Destination decode and ready: a full slot is writable only while it is being acked.
    always_comb begin
        w_dest = bus.s;
        if (sel_mode_e'(bus.auto) == SEL_AUTO) begin
            w_dest = r_ptr;
        end else begin
            w_dest = bus.s;
        end
        w_in_ready = Resetn & (~w_valid[w_dest] | bus.out_ack[w_dest]);
        w_accept   = bus.in_valid & w_in_ready;
        if (w_accept) begin
            w_wr = chan_onehot(w_dest);
        end else begin
            w_wr = 4'b0000;
        end
    end

    // Round-robin pointer advances only on accepts made in auto mode.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_accept && (sel_mode_e'(bus.auto) == SEL_AUTO)) begin
            w_ptr_nxt = ptr_next(r_ptr);
        end else begin
            w_ptr_nxt = r_ptr;
        end
    end

    // Pointer register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_ptr <= CH_U;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .Clock  (Clock),
            .Resetn (Resetn),
            .wr     (w_wr[gi]),
            .ack    (bus.out_ack[gi]),
            .d      (bus.d),
            .q      (w_q[gi]),
            .valid  (w_valid[gi])
        );
    end

    assign bus.u         = w_q[CH_U];
    assign bus.v         = w_q[CH_V];
    assign bus.w         = w_q[CH_W];
    assign bus.x         = w_q[CH_X];
    assign bus.out_valid = w_valid;
    assign bus.ptr       = r_ptr;
    assign bus.in_ready  = w_in_ready;

endmodule
